complex_mult_pipe: RTL and testbench
====================================

// Module: complex_mult_pipe
// PURPOSE
//   Parametrised, fully pipelined complex multiplier with valid/ready flow control.
//   Computes a*b, or a*conj(b) when selected per sample.
//   Output is right-shifted with round-half-up, then saturated, with per-sample and
//   cumulative overflow reporting.
//   Sits in the DSP chain between the mixer/correlator stages and downstream filters.
// PARAMETERS
//   WA     16  width of operand a (I and Q each), signed two's complement
//   WB     16  width of operand b (I and Q each), signed
//   WO     16  width of output I/Q, signed
//   SHIFT  15  right shift applied to the full-precision result, 0..WA+WB
//   CNT_W  16  width of the saturation event counter
// PORTS
//   clk        in   1      clock, all state on rising edge
//   reset      in   1      asynchronous reset, active high
//   in_valid   in   1      input sample valid
//   in_ready   out  1      block accepts input this cycle
//   a_i, a_q   in   WA     operand a, real/imag
//   b_i, b_q   in   WB     operand b, real/imag
//   conj_b     in   1      1: use conj(b) for this sample (travels with data)
//   out_valid  out  1      output sample valid
//   out_ready  in   1      downstream accepts output
//   out_i      out  WO     result real
//   out_q      out  WO     result imag
//   out_sat    out  1      1: out_i or out_q was clipped for this sample
//   sat_cnt    out  CNT_W  count of saturated samples, sticks at all-ones
//   clr_cnt    in   1      synchronous clear of sat_cnt
// BEHAVIOUR
// - Reset: all valid flags, out_i, out_q, out_sat and sat_cnt go to 0 immediately.
//   In-flight samples are discarded.
// - Stage registers:
//   S1 = input regs (a, b, conj).
//   S2 = four WA+WB-bit products ii, qq, iq, qi.
//   S3 = output regs.
// - Latency: 3 clk from accepted input to out_valid when not stalled.
//   Throughput is 1 sample/clk.
// - Flow control uses a global enable: en = out_ready | ~out_valid.
//   - in_ready = en (combinational from out_ready).
//   - When en=0, all stages hold, including their valid bits.
//   - Handshake: a transfer occurs when valid & ready. out_* stay stable while
//     out_valid & ~out_ready.
//   - Bubbles (valid=0) propagate and never produce out_valid.
// - Arithmetic, full precision WF = WA+WB+1, no overflow possible:
//   - conj=0: re = ii - qq, im = qi + iq.
//   - conj=1: re = ii + qq, im = qi - iq.
// - Scaling:
//   - When SHIFT>0: r = (x + 2^(SHIFT-1)) >>> SHIFT, arithmetic (round half up,
//     toward +inf on ties). When SHIFT=0: r = x.
//   - Rounding add uses WF+1 bits.
// - Saturation: if r > 2^(WO-1)-1, output 2^(WO-1)-1; if r < -2^(WO-1), output -2^(WO-1).
//   out_sat = OR of both clip events, registered with the sample.
// - sat_cnt:
//   - Increments by 1 on each output transfer (out_valid & out_ready) with out_sat=1.
//   - Holds at 2^CNT_W-1.
//   - clr_cnt has priority over increment in the same cycle; the result is 0.
// - Stalls never alter, duplicate or drop samples; output order equals input order.
// STRUCTURE
// - Shared package dsp_pkg:
//   - Function sat_round(x, SHIFT, WO) returning {sat, value}.
//   - Localparam WF = WA+WB+1.
// - One sub-module: cplx_sat_round (combinational).
//   - Rounds and saturates one I/Q pair, WF in, WO out, plus sat flag.
//   - Instantiated once, feeding S3.
// - Pipeline valid bits v1, v2, v3 (v3 = out_valid) are plain regs gated by en.
// TESTING (defaults WA=WB=WO=16, SHIFT=15)
// 1. a=(16384,0), b=(16384,0), conj=0
//    -> out=(8192,0), out_sat=0, out_valid exactly 3 clk after accept.
// 2. a=(0,16384), b=(0,16384): conj=0 -> (-8192,0); conj=1 -> (8192,0).
//    Sent back to back, both appear on consecutive cycles.
// 3. a=(-32768,-32768), b=(-32768,-32768):
//    conj=1 -> (32767,0), out_sat=1, sat_cnt=1.
//    conj=0 -> (0,32767), out_sat=1, sat_cnt=2.
//    Then clr_cnt -> sat_cnt=0.
// 4. Rounding: a=(1,0), b=(16384,0) -> (1,0); a=(-1,0), b=(16384,0) -> (0,0).
// 5. Stream 16 random samples, out_ready=0 for 4 cycles mid-stream.
//    -> in_ready=0 during the hold, out_* stable.
//    -> Output sequence matches the model with no loss or duplication.
// 6. Assert reset with 2 samples in flight
//    -> out_valid=0, sat_cnt=0 next edge, nothing emitted after release.
//    Also: 300 forced saturations with CNT_W=8 -> sat_cnt sticks at 255.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: widths and the round/saturate helper.
// Used by the complex multiplier pipeline and its scaler.
package dsp_pkg;

    localparam int WA_DEF = 16;
    localparam int WB_DEF = 16;
    localparam int WF     = WA_DEF + WB_DEF + 1;
    localparam int XW     = 64;

    // Returns {sat, value}; value is round-half-up shifted and clipped to wo bits.
    function automatic logic [XW:0] sat_round(
        input logic signed [XW-1:0] x,
        input int                   shift,
        input int                   wo
    );
        logic signed [XW-1:0] r;
        logic signed [XW-1:0] hi;
        logic signed [XW-1:0] lo;
        logic                 sat;
        r = x;
        if (shift > 0) begin
            r = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi  = (64'sd1 <<< (wo - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (wo - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return {sat, r};
    endfunction

endpackage

// File: rtl/complex_mult_pipe_sat_round.sv
// Rounds and saturates one full-precision I/Q pair to WO bits.
// Purely combinational; the caller registers the result.
module cplx_sat_round
    import dsp_pkg::*;
#(
    parameter int WIN   = 33,
    parameter int WO    = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [WIN-1:0] re,
    input  logic signed [WIN-1:0] im,
    output logic signed [WO-1:0]  out_i,
    output logic signed [WO-1:0]  out_q,
    output logic                  sat
);

    logic [XW:0] res_i;
    logic [XW:0] res_q;
    logic        unused_hi;

    // Scale both components and merge their clip flags.
    always_comb begin
        res_i     = sat_round(XW'(re), SHIFT, WO);
        res_q     = sat_round(XW'(im), SHIFT, WO);
        out_i     = res_i[WO-1:0];
        out_q     = res_q[WO-1:0];
        sat       = res_i[XW] | res_q[XW];
        unused_hi = ^{res_i[XW-1:WO], res_q[XW-1:WO]};
    end

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage complex multiplier a*b or a*conj(b) with valid/ready.
// Global enable stalls every stage together when the output is blocked.
module complex_mult_pipe
    import dsp_pkg::*;
#(
    parameter int WA    = 16,
    parameter int WB    = 16,
    parameter int WO    = 16,
    parameter int SHIFT = 15,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WA-1:0] a_i,
    input  logic signed [WA-1:0] a_q,
    input  logic signed [WB-1:0] b_i,
    input  logic signed [WB-1:0] b_q,
    input  logic                 conj_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WO-1:0] out_i,
    output logic signed [WO-1:0] out_q,
    output logic                 out_sat,
    output logic [CNT_W-1:0]     sat_cnt,
    input  logic                 clr_cnt
);

    localparam int WP  = WA + WB;
    localparam int WFP = WA + WB + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  en;
    logic                  v1, v2;
    logic signed [WA-1:0]  s1_ai, s1_aq;
    logic signed [WB-1:0]  s1_bi, s1_bq;
    logic                  s1_cj;
    logic signed [WP-1:0]  ii, qq, iq, qi;
    logic                  s2_cj;
    logic signed [WFP-1:0] re, im;
    logic signed [WO-1:0]  r_i, r_q;
    logic                  r_sat;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    // S1: capture operands and the conjugate select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1    <= 1'b0;
            s1_ai <= '0;
            s1_aq <= '0;
            s1_bi <= '0;
            s1_bq <= '0;
            s1_cj <= 1'b0;
        end else if (en) begin
            v1    <= in_valid;
            s1_ai <= a_i;
            s1_aq <= a_q;
            s1_bi <= b_i;
            s1_bq <= b_q;
            s1_cj <= conj_b;
        end
    end

    // S2: four full-width partial products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2    <= 1'b0;
            ii    <= '0;
            qq    <= '0;
            iq    <= '0;
            qi    <= '0;
            s2_cj <= 1'b0;
        end else if (en) begin
            v2    <= v1;
            ii    <= WP'(s1_ai) * WP'(s1_bi);
            qq    <= WP'(s1_aq) * WP'(s1_bq);
            iq    <= WP'(s1_ai) * WP'(s1_bq);
            qi    <= WP'(s1_aq) * WP'(s1_bi);
            s2_cj <= s1_cj;
        end
    end

    // Combine products; one extra bit keeps the sum exact.
    always_comb begin
        if (s2_cj) begin
            re = WFP'(ii) + WFP'(qq);
            im = WFP'(qi) - WFP'(iq);
        end else begin
            re = WFP'(ii) - WFP'(qq);
            im = WFP'(qi) + WFP'(iq);
        end
    end

    cplx_sat_round #(
        .WIN   (WFP),
        .WO    (WO),
        .SHIFT (SHIFT)
    ) u_scale (
        .re    (re),
        .im    (im),
        .out_i (r_i),
        .out_q (r_q),
        .sat   (r_sat)
    );

    // S3: output register, held while downstream is not ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            out_i     <= r_i;
            out_q     <= r_q;
            out_sat   <= r_sat;
        end
    end

    // Count clipped samples as they leave; clear wins, top value sticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_cnt <= '0;
        end else if (clr_cnt) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && out_sat
                     && sat_cnt != CNT_MAX) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Self-checking bench for complex_mult_pipe.
// Directed table, back-to-back, stall stream, counter and reset cases.
module tb_complex_mult_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready, d8_in_ready;
    logic signed [15:0] a_i, a_q, b_i, b_q;
    logic               conj_b;
    logic               out_valid, d8_out_valid;
    logic               out_ready;
    logic signed [15:0] out_i, out_q, d8_out_i, d8_out_q;
    logic               out_sat, d8_out_sat;
    logic [15:0]        sat_cnt;
    logic [7:0]         d8_sat_cnt;
    logic               clr_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    complex_mult_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
        .conj_b(conj_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_sat(out_sat),
        .sat_cnt(sat_cnt), .clr_cnt(clr_cnt)
    );

    complex_mult_pipe #(.CNT_W(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(d8_in_ready),
        .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
        .conj_b(conj_b),
        .out_valid(d8_out_valid), .out_ready(out_ready),
        .out_i(d8_out_i), .out_q(d8_out_q), .out_sat(d8_out_sat),
        .sat_cnt(d8_sat_cnt), .clr_cnt(clr_cnt)
    );

    typedef struct {
        int ai, aq, bi, bq;
        bit cj;
        int ei, eq;
        bit es;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: exact complex product, round half up, clip to 16 bits.
    function automatic logic [32:0] model(input int ai, input int aq,
                                          input int bi, input int bq,
                                          input bit cj);
        longint re, im, ri, rq;
        bit s;
        if (cj) begin
            re = longint'(ai) * bi + longint'(aq) * bq;
            im = longint'(aq) * bi - longint'(ai) * bq;
        end else begin
            re = longint'(ai) * bi - longint'(aq) * bq;
            im = longint'(aq) * bi + longint'(ai) * bq;
        end
        ri = (re + 16384) >>> 15;
        rq = (im + 16384) >>> 15;
        s  = 1'b0;
        if (ri > 32767)  begin ri = 32767;  s = 1'b1; end
        if (ri < -32768) begin ri = -32768; s = 1'b1; end
        if (rq > 32767)  begin rq = 32767;  s = 1'b1; end
        if (rq < -32768) begin rq = -32768; s = 1'b1; end
        return {s, 16'(rq), 16'(ri)};
    endfunction

    task automatic drive(input int ai, input int aq, input int bi,
                         input int bq, input bit cj);
        in_valid = 1'b1;
        a_i = 16'(ai); a_q = 16'(aq);
        b_i = 16'(bi); b_q = 16'(bq);
        conj_b = cj;
    endtask

    initial begin
        vec_t vt[6];
        int ecnt;
        int lat;
        logic [32:0] exq[$];
        logic [32:0] e, held;
        int sent, got, cyc;
        bit acc, stalled;
        logic [15:0] r0, r1, r2, r3;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        a_i = '0; a_q = '0; b_i = '0; b_q = '0; conj_b = 1'b0;
        ecnt = 0;

        vt[0] = '{16384, 0, 16384, 0, 1'b0, 8192, 0, 1'b0};
        vt[1] = '{0, 16384, 0, 16384, 1'b0, -8192, 0, 1'b0};
        vt[2] = '{-32768, -32768, -32768, -32768, 1'b1, 32767, 0, 1'b1};
        vt[3] = '{-32768, -32768, -32768, -32768, 1'b0, 0, 32767, 1'b1};
        vt[4] = '{1, 0, 16384, 0, 1'b0, 1, 0, 1'b0};
        vt[5] = '{-1, 0, 16384, 0, 1'b0, 0, 0, 1'b0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_i", out_i, 0);
        chk("rst_out_q", out_q, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_cnt", sat_cnt, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Directed vectors one at a time, with latency.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(vt[k].ai, vt[k].aq, vt[k].bi, vt[k].bq, vt[k].cj);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("latency_%0d", k), lat, 3);
            chk($sformatf("out_i_%0d", k), out_i, vt[k].ei);
            chk($sformatf("out_q_%0d", k), out_q, vt[k].eq);
            chk($sformatf("out_sat_%0d", k), out_sat, vt[k].es);
            if (vt[k].es) ecnt++;
            @(posedge clk); #1;
            chk($sformatf("sat_cnt_%0d", k), sat_cnt, ecnt);
        end

        // Clear counter.
        clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
        chk("clr_cnt", sat_cnt, 0);

        // Back-to-back a*b and a*conj(b).
        drive(0, 16384, 0, 16384, 1'b0);
        @(posedge clk); #1;
        drive(0, 16384, 0, 16384, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_first_i", out_i, -8192);
        @(posedge clk); #1;
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_i", out_i, 8192);

        // Random stream with a 4-cycle output stall.
        sent = 0; got = 0; cyc = 0; acc = 0; stalled = 0; held = '0;
        in_valid = 1'b0;
        while ((sent < 16 || exq.size() > 0) && cyc < 300) begin
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            acc = 0;
            out_ready = !(cyc >= 8 && cyc < 12);
            if (!in_valid && sent < 16 &&
                ((cyc >= 4 && cyc <= 12) || $urandom_range(3) != 0)) begin
                r0 = 16'($urandom()); r1 = 16'($urandom());
                r2 = 16'($urandom()); r3 = 16'($urandom());
                drive(int'($signed(r0)), int'($signed(r1)),
                      int'($signed(r2)), int'($signed(r3)),
                      1'($urandom_range(1)));
            end
            @(negedge clk);
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", in_ready, 0);
                if (stalled)
                    chk("stall_hold", {out_sat, out_q, out_i}, held);
                held = {out_sat, out_q, out_i};
                stalled = 1;
            end else begin
                stalled = 0;
            end
            if (out_valid && out_ready) begin
                if (exq.size() == 0) begin
                    chk("stream_extra", 1, 0);
                end else begin
                    e = exq.pop_front();
                    chk($sformatf("stream_%0d", got),
                        {out_sat, out_q, out_i}, e);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exq.push_back(model(a_i, a_q, b_i, b_q, conj_b));
                sent++;
                acc = 1;
            end
            cyc++;
        end
        chk("stream_count", got, 16);
        out_ready = 1'b1;
        in_valid = 1'b0;

        // 300 forced saturations; 8-bit counter must stick.
        @(posedge clk); #1 clr_cnt = 1'b1;
        @(posedge clk); #1 clr_cnt = 1'b0;
        for (int n = 0; n < 300; n++) begin
            drive(-32768, -32768, -32768, -32768, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("sat_cnt_300", sat_cnt, 300);
        chk("sat_cnt8_stick", d8_sat_cnt, 255);

        // Reset with two samples in flight.
        drive(-32768, -32768, -32768, -32768, 1'b0);
        @(posedge clk); #1;
        drive(16384, 0, 16384, 0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("inflight_rst_valid", out_valid, 0);
        chk("inflight_rst_cnt", sat_cnt, 0);
        chk("inflight_rst_cnt8", d8_sat_cnt, 0);
        @(posedge clk); #1 reset = 1'b0;
        lat = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        chk("post_rst_no_output", lat, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
